mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 16-to-1 analog/digital mux: steps sel through all channels,
// waits SETTLE cycles on enabled channels, samples mux_out into word, then hands it off.
// state    | meaning
// S_IDLE   | waiting for start
// S_SETTLE | sel stable, waiting for the mux output to settle
// S_SAMPLE | capture mux_out into word[sel] (skip capture if masked), advance channel
// S_DONE   | word_valid high, waiting for word_ready
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam int         LP_LOAD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0] LP_LOAD   = LP_LOAD_I[3:0];
  localparam logic       LP_HAS_SETTLE = (SETTLE > 0);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_sel;
  logic [3:0]  r_cnt;
  logic [15:0] r_mask;
  logic [15:0] r_word;
  logic        r_overrun;
  logic [3:0]  w_sel_next;

  assign w_sel_next = r_sel + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Masked channels skip SETTLE and spend their single cycle in S_SAMPLE without capturing.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_state_next = (mask[0] && LP_HAS_SETTLE) ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (r_sel == 4'd15)
          w_state_next = S_DONE;
        else
          w_state_next = (r_mask[w_sel_next] && LP_HAS_SETTLE) ? S_SETTLE : S_SAMPLE;
      end
      S_DONE: begin
        if (word_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    word_valid = 1'b0;
    case (r_state)
      S_SETTLE, S_SAMPLE: busy       = 1'b1;
      S_DONE:             word_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= 4'd0;
      r_cnt     <= 4'd0;
      r_mask    <= 16'h0000;
      r_word    <= 16'h0000;
      r_overrun <= 1'b0;
    end else begin
      if (start && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask <= mask;
            r_sel  <= 4'd0;
            r_word <= 16'h0000;
            r_cnt  <= LP_LOAD;
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_SAMPLE: begin
          if (r_mask[r_sel]) r_word[r_sel] <= mux_out;
          // Wraps 15 -> 0 so sel reads 0 in DONE.
          r_sel <= w_sel_next;
          r_cnt <= LP_LOAD;
        end
        default: ;
      endcase
    end
  end

  assign sel     = r_sel;
  assign word    = r_word;
  assign overrun = r_overrun;

endmodule
